poly_voice_synth: RTL and testbench



---
 rtl/poly_voice_synth.sv | 176 +++++++++++++++++
 tb/tb_poly_voice_synth.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/poly_voice_synth.sv
// Time-multiplexed oscillator bank: one voice per clock, mixed into a saturated sample; define POLY_VOICE_SYNTH_WAVES_EN for saw/triangle.
// Latency: tick in cycle T, out_valid in cycle T+NUM_VOICES+1; all outputs registered.
// Backpressure: out_valid/out_sample hold until out_ready; ticks arriving while busy are dropped and flag overrun.
module poly_voice_synth #(
    parameter int NUM_VOICES = 8,
    parameter int SAMPLE_W   = 16,
    parameter int VOL_W      = 21
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        sample_tick,
    input  logic [NUM_VOICES*32-1:0]    phase_inc,
    input  logic [NUM_VOICES*VOL_W-1:0] volume,
    input  logic [NUM_VOICES*2-1:0]     wave_sel,
    input  logic                        overrun_clr,
    output logic [SAMPLE_W-1:0]         out_sample,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        overrun
);

    localparam int VI_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int ACC_W  = 40;
    localparam int PROD_W = VOL_W + 17;
    localparam int SH_W   = ACC_W + SAMPLE_W - 16;

    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

    state_t                   state, state_nxt;
    logic [VI_W-1:0]          vidx;
    logic signed [ACC_W-1:0]  acc;
    logic [31:0]              phase [NUM_VOICES];

    logic                     handshake, last_voice;
    logic                     start_frame, voice_en, load_out, drop;

    logic [31:0]              inc_v, ph_v, ph_new;
    logic [VOL_W-1:0]         vol_v;
    logic signed [15:0]       wave;
    logic signed [VOL_W:0]    vol_s;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [SH_W-1:0]   shifted;
    logic [SH_W-SAMPLE_W:0]   top_bits;
    logic [SAMPLE_W-1:0]      sat;

    assign handshake  = out_valid & out_ready;
    assign last_voice = (vidx == VI_W'(NUM_VOICES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sample_tick) state_nxt = ACCUM;
            ACCUM:   if (last_voice)  state_nxt = OUTPUT;
            OUTPUT:  if (handshake)   state_nxt = sample_tick ? ACCUM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_frame = 1'b0;
        voice_en    = 1'b0;
        load_out    = 1'b0;
        drop        = 1'b0;
        case (state)
            IDLE:    start_frame = sample_tick;
            ACCUM: begin
                voice_en = 1'b1;
                load_out = last_voice;
                drop     = sample_tick;
            end
            OUTPUT: begin
                start_frame = sample_tick & handshake;
                drop        = sample_tick & ~handshake;
            end
            default: ;
        endcase
    end

`ifdef POLY_VOICE_SYNTH_WAVES_EN
    logic [1:0]  sel_v;
    logic [14:0] tri_val;
`else
    logic unused_sel;
    assign unused_sel = ^wave_sel;
`endif

    // Per-voice inputs are only looked at during that voice's slot.
    always_comb begin
        inc_v = '0;
        vol_v = '0;
        ph_v  = '0;
`ifdef POLY_VOICE_SYNTH_WAVES_EN
        sel_v = '0;
`endif
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (vidx == VI_W'(v)) begin
                inc_v = phase_inc[v*32 +: 32];
                vol_v = volume[v*VOL_W +: VOL_W];
                ph_v  = phase[v];
`ifdef POLY_VOICE_SYNTH_WAVES_EN
                sel_v = wave_sel[v*2 +: 2];
`endif
            end
        end
    end

    assign ph_new = ph_v + inc_v;

    always_comb begin
        wave = ph_new[31] ? -16'sd16384 : 16'sd16384;
`ifdef POLY_VOICE_SYNTH_WAVES_EN
        tri_val = ph_new[31] ? ~ph_new[30:16] : ph_new[30:16];
        case (sel_v)
            2'd1:    wave = $signed({1'b0, ph_new[31:17]}) - 16'sd16384;
            2'd2:    wave = $signed({1'b0, tri_val}) - 16'sd16384;
            default: ;
        endcase
`endif
    end

    // Arithmetic shift of the product floors toward minus infinity.
    assign vol_s   = $signed({1'b0, vol_v});
    assign prod    = PROD_W'(wave) * PROD_W'(vol_s);
    assign acc_sum = acc + ACC_W'(prod >>> 20);

    // Widening then shifting by the same amount discards the padding bits.
    assign shifted  = SH_W'(acc_sum) <<< (SAMPLE_W - 16);
    assign top_bits = shifted[SH_W-1:SAMPLE_W-1];

    always_comb begin
        if ((&top_bits) || !(|top_bits))
            sat = shifted[SAMPLE_W-1:0];
        else if (shifted[SH_W-1])
            sat = {1'b1, {(SAMPLE_W-1){1'b0}}};
        else
            sat = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vidx       <= '0;
            acc        <= '0;
            out_sample <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) phase[v] <= '0;
        end else begin
            if (start_frame) begin
                vidx <= '0;
                acc  <= '0;
            end else if (voice_en) begin
                vidx <= last_voice ? '0 : vidx + 1'b1;
                acc  <= acc_sum;
            end
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (voice_en && (vidx == VI_W'(v))) phase[v] <= ph_new;
            end
            if (load_out) begin
                out_sample <= sat;
                out_valid  <= 1'b1;
            end else if (handshake) begin
                out_valid  <= 1'b0;
            end
            // A dropped tick beats a simultaneous clear.
            if (drop)             overrun <= 1'b1;
            else if (overrun_clr) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_poly_voice_synth.sv
// Scoreboard bench for poly_voice_synth: expected frames are queued at tick time, a monitor compares on each handshake.
module tb_poly_voice_synth;
    localparam int NV = 8;
    localparam int SW = 16;
    localparam int VW = 21;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              sample_tick;
    logic [NV*32-1:0]  phase_inc;
    logic [NV*VW-1:0]  volume;
    logic [NV*2-1:0]   wave_sel;
    logic              overrun_clr;
    logic [SW-1:0]     out_sample;
    logic              out_valid;
    logic              out_ready;
    logic              overrun;

    poly_voice_synth #(.NUM_VOICES(NV), .SAMPLE_W(SW), .VOL_W(VW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sample_tick (sample_tick),
        .phase_inc   (phase_inc),
        .volume      (volume),
        .wave_sel    (wave_sel),
        .overrun_clr (overrun_clr),
        .out_sample  (out_sample),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   vectors = 0;
    int   miscompares = 0;
    int   exp_q[$];
    int   tick_q[$];
    logic prev_valid = 1'b0;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: latency on each rising out_valid, sample value on each handshake.
    always @(negedge clk) begin : monitor
        int t;
        if (reset_n) begin
            if (out_valid && !prev_valid) begin
                if (tick_q.size() == 0) check("unexpected_valid", 1, 0);
                else begin
                    t = tick_q.pop_front();
                    check("latency", cyc - t, NV + 1);
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_frame", 1, 0);
                else check("sample", $signed(out_sample), exp_q.pop_front());
            end
        end
        prev_valid = out_valid;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic set_voice(input int v, input logic [31:0] inc, input logic [VW-1:0] vol,
                             input logic [1:0] sel);
        phase_inc[v*32 +: 32] = inc;
        volume[v*VW +: VW]    = vol;
        wave_sel[v*2 +: 2]    = sel;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n     = 1'b0;
        sample_tick = 1'b0;
        overrun_clr = 1'b0;
        out_ready   = 1'b1;
        phase_inc   = '0;
        volume      = '0;
        wave_sel    = '0;
        exp_q.delete();
        tick_q.delete();
        wait_cycles(2);
        #1 reset_n = 1'b1;
    endtask

    // Tick is high for one cycle; accepted ticks enqueue their expected frame.
    task automatic tick(input int expv, input bit accepted);
        @(posedge clk); #1;
        sample_tick = 1'b1;
        if (accepted) begin
            exp_q.push_back(expv);
            tick_q.push_back(cyc);
        end
        @(posedge clk); #1;
        sample_tick = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 overrun_clr = 1'b1;
        @(posedge clk); #1 overrun_clr = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        check(name, exp_q.size(), 0);
        wait_cycles(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; sample_tick = 1'b0; overrun_clr = 1'b0; out_ready = 1'b1;
        phase_inc = '0; volume = '0; wave_sel = '0;
        wait_cycles(3);
        @(negedge clk);
        check("rst_sample", $signed(out_sample), 0);
        check("rst_valid", out_valid, 0);
        check("rst_overrun", overrun, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        tick(0, 1);
        drain("silent_drain");

        // Square, ticks 9 cycles apart: each lands on the previous frame's handshake.
        do_reset();
        set_voice(0, 32'h4000_0000, 21'd1 << 20, 2'd0);
        tick(16384, 1);  wait_cycles(7);
        tick(-16384, 1); wait_cycles(7);
        tick(-16384, 1); wait_cycles(7);
        tick(16384, 1);
        drain("square_drain");
        check("square_overrun", overrun, 0);

        do_reset();
        for (int v = 0; v < NV; v++) set_voice(v, 32'h4000_0000, 21'd1 << 20, (v % 2) ? 2'd3 : 2'd0);
        tick(32767, 1);  wait_cycles(8);
        tick(-32768, 1); wait_cycles(8);
        tick(-32768, 1);
        drain("sat_drain");

        do_reset();
        set_voice(0, 32'h2000_0000, 21'd1 << 19, 2'd1);
`ifdef POLY_VOICE_SYNTH_WAVES_EN
        tick(-6144, 1); wait_cycles(8);
        tick(-4096, 1);
`else
        tick(8192, 1); wait_cycles(8);
        tick(8192, 1);
`endif
        drain("saw_drain");

        // Triangle near the fold plus a tiny-gain saw that must floor to -1.
        do_reset();
        set_voice(0, 32'h2000_0000, 21'd3, 2'd1);
        set_voice(1, 32'hC000_0000, 21'd1 << 20, 2'd2);
`ifdef POLY_VOICE_SYNTH_WAVES_EN
        tick(-2, 1); wait_cycles(8);
        tick(16382, 1);
`else
        tick(-16384, 1); wait_cycles(8);
        tick(-16384, 1);
`endif
        drain("tri_drain");

        do_reset();
        set_voice(0, 32'h4000_0000, 21'd1 << 20, 2'd0);
        out_ready = 1'b0;
        tick(16384, 1);
        for (int i = 0; i < 40 && !out_valid; i++) @(posedge clk);
        tick(0, 0);
        @(negedge clk);
        check("bp_overrun_set", overrun, 1);
        check("bp_valid_held", out_valid, 1);
        check("bp_sample_held", $signed(out_sample), 16384);
        pulse_clr();
        @(negedge clk);
        check("bp_overrun_clr", overrun, 0);
        @(posedge clk); #1 sample_tick = 1'b1; overrun_clr = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0; overrun_clr = 1'b0;
        @(negedge clk);
        check("bp_set_wins", overrun, 1);
        pulse_clr();
        @(negedge clk);
        check("bp_overrun_clr2", overrun, 0);
        out_ready = 1'b1;
        drain("bp_release");
        tick(-16384, 1);
        tick(0, 0);
        drain("bp_accum_drain");
        check("bp_accum_overrun", overrun, 1);
        tick(-16384, 1);
        drain("bp_no_advance");
        pulse_clr();

        // Reset while voice 3 is being processed discards the frame and the phases.
        do_reset();
        set_voice(0, 32'h4000_0000, 21'd1 << 20, 2'd0);
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        wait_cycles(3);
        #1 reset_n = 1'b0;
        @(negedge clk);
        check("midrst_valid", out_valid, 0);
        check("midrst_sample", $signed(out_sample), 0);
        @(posedge clk); #1 reset_n = 1'b1;
        wait_cycles(12);
        @(negedge clk);
        check("midrst_no_frame", out_valid, 0);
        tick(16384, 1);
        drain("midrst_drain");

        wait_cycles(5);
        check("final_queues", exp_q.size() + tick_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
